// File: rtl/xgmii_pkg.sv
// xgmii_pkg: shared XGMII control characters, pre-built 64-bit words, the
// frame generator state encoding and a tkeep decoder.
//   tkeep_to_len(tkeep) -> {len, valid}: len = number of enabled bytes (0..8),
//   valid = enabled bytes are contiguous starting at lane 0 (0x00 counts as
//   contiguous; callers reject an empty last beat themselves).
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] PREAMBLE    = 8'h55;
  localparam logic [7:0] SFD         = 8'hD5;

  localparam logic [63:0] IDLE_WORD     = {8{XGMII_IDLE}};
  localparam logic [63:0] ERROR_WORD    = {8{XGMII_ERROR}};
  localparam logic [63:0] PREAMBLE_WORD = {SFD, {6{PREAMBLE}}, XGMII_START};
  localparam logic [63:0] TERM_WORD     = {{7{XGMII_IDLE}}, XGMII_TERM};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_TERM,
    ST_DROP,
    ST_IFG
  } state_t;

  typedef struct packed {
    logic [3:0] len;
    logic       valid;
  } keep_info_t;

  function automatic keep_info_t tkeep_to_len(input logic [7:0] tkeep);
    keep_info_t r;
    logic       seen_zero;
    r.len     = 4'd0;
    r.valid   = 1'b1;
    seen_zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tkeep[i]) begin
        // an enabled byte above a disabled one breaks contiguity
        if (seen_zero) r.valid = 1'b0;
        r.len = r.len + 4'd1;
      end else begin
        seen_zero = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xgmii_frame_gen_if.sv
// xgmii_frame_gen_if: 64-bit AXI-Stream frame channel.
//   tdata  64  frame bytes, byte 0 = bits [7:0]
//   tkeep   8  byte enables
//   tvalid  1  beat valid
//   tlast   1  last beat of frame
//   tready  1  sink accepts the beat when tvalid && tready
// master drives the beats, slave returns tready.
interface xgmii_frame_gen_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/xgmii_frame_gen.sv
// xgmii_frame_gen: turns AXI-Stream Ethernet frames (FCS included) into a
// lane-0-aligned XGMII transmit stream: start/preamble/SFD, data, terminate,
// then at least MIN_IFG bytes of gap counted from the /T/ byte inclusive.
// Underruns and malformed tkeep are flagged on the wire with an all-/E/ word.
// Ports:
//   clk          XGMII clock, rising edge
//   rst_n        synchronous active-low reset
//   s_axis       AXI-Stream slave (tdata/tkeep/tvalid/tlast in, tready out)
//   xgmii_txd    64-bit XGMII data, lane i = bits [8i+7:8i] (registered)
//   xgmii_txc    8-bit XGMII control, bit i qualifies lane i (registered)
//   frame_count  frames closed with a valid /T/, wraps
//   error_count  frames aborted with /E/, wraps
// The state tells what is on the wire now: a start is launched from IDLE/IFG
// by registering the preamble word directly, so the preamble appears one cycle
// after tvalid is seen. tready is high while the preamble or data is on the
// wire, so the first beat is taken under the preamble and data follows with no
// hole.
module xgmii_frame_gen
  import xgmii_pkg::*;
#(
  parameter int MIN_IFG = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  xgmii_frame_gen_if.slave   s_axis,
  output logic [63:0]        xgmii_txd,
  output logic [7:0]         xgmii_txc,
  output logic [31:0]        frame_count,
  output logic [31:0]        error_count
);

  localparam int GAP_W = $clog2(MIN_IFG + 9);

  state_t             state_reg, state_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic [63:0]        txd_reg, txd_next;
  logic [7:0]         txc_reg, txc_next;
  logic [31:0]        frame_count_reg, error_count_reg;
  logic               tready_reg;
  logic               frame_inc, error_inc;
  logic               gap_ok;
  keep_info_t         keep_info;

  // Gap bytes saturate at MIN_IFG; only "reached or not" matters.
  function automatic logic [GAP_W-1:0] gap_sat(input int bytes);
    if (bytes >= MIN_IFG) return GAP_W'(MIN_IFG);
    return GAP_W'(bytes);
  endfunction

  assign keep_info = tkeep_to_len(s_axis.tkeep);
  assign gap_ok    = (int'(gap_reg) >= MIN_IFG);

  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    txd_next   = IDLE_WORD;
    txc_next   = 8'hFF;
    frame_inc  = 1'b0;
    error_inc  = 1'b0;
    unique case (state_reg)
      ST_IDLE, ST_IFG: begin
        if (gap_ok && s_axis.tvalid) begin
          txd_next   = PREAMBLE_WORD;
          txc_next   = 8'h01;
          state_next = ST_PREAMBLE;
        end else begin
          gap_next = gap_sat(int'(gap_reg) + 8);
          if (int'(gap_next) >= MIN_IFG) state_next = ST_IDLE;
        end
      end
      ST_PREAMBLE, ST_DATA: begin
        state_next = ST_DATA;
        if (!s_axis.tvalid) begin
          // underrun: the frame cannot be completed, poison it
          txd_next   = ERROR_WORD;
          error_inc  = 1'b1;
          gap_next   = gap_sat(8);
          state_next = ST_DROP;
        end else if (!s_axis.tlast) begin
          if (s_axis.tkeep == 8'hFF) begin
            txd_next = s_axis.tdata;
            txc_next = 8'h00;
          end else begin
            txd_next   = ERROR_WORD;
            error_inc  = 1'b1;
            gap_next   = gap_sat(8);
            state_next = ST_DROP;
          end
        end else if (!keep_info.valid || keep_info.len == 4'd0) begin
          txd_next   = ERROR_WORD;
          error_inc  = 1'b1;
          gap_next   = gap_sat(8);
          state_next = ST_IFG;
        end else if (keep_info.len == 4'd8) begin
          // full last beat: /T/ goes out in its own word next cycle
          txd_next   = s_axis.tdata;
          txc_next   = 8'h00;
          state_next = ST_TERM;
        end else begin
          // partial last beat: data, /T/ in lane len, idles above
          for (int i = 0; i < 8; i++) begin
            if (i < int'(keep_info.len)) begin
              txd_next[8*i +: 8] = s_axis.tdata[8*i +: 8];
              txc_next[i]        = 1'b0;
            end else if (i == int'(keep_info.len)) begin
              txd_next[8*i +: 8] = XGMII_TERM;
            end
          end
          frame_inc  = 1'b1;
          gap_next   = gap_sat(8 - int'(keep_info.len));
          state_next = ST_IFG;
        end
      end
      ST_TERM: begin
        txd_next   = TERM_WORD;
        frame_inc  = 1'b1;
        gap_next   = gap_sat(8);
        state_next = ST_IFG;
      end
      ST_DROP: begin
        // discard the rest of the aborted frame; these idles count as gap
        gap_next = gap_sat(int'(gap_reg) + 8);
        if (s_axis.tvalid && s_axis.tlast) state_next = ST_IFG;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      gap_reg         <= GAP_W'(MIN_IFG);
      txd_reg         <= IDLE_WORD;
      txc_reg         <= 8'hFF;
      frame_count_reg <= 32'd0;
      error_count_reg <= 32'd0;
      tready_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      gap_reg         <= gap_next;
      txd_reg         <= txd_next;
      txc_reg         <= txc_next;
      frame_count_reg <= frame_count_reg + 32'(frame_inc);
      error_count_reg <= error_count_reg + 32'(error_inc);
      tready_reg      <= (state_next == ST_PREAMBLE) || (state_next == ST_DATA) ||
                         (state_next == ST_DROP);
    end
  end

  assign s_axis.tready = tready_reg;
  assign xgmii_txd     = txd_reg;
  assign xgmii_txc     = txc_reg;
  assign frame_count   = frame_count_reg;
  assign error_count   = error_count_reg;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Bench for xgmii_frame_gen. The model describes each frame as the byte stream
// that must appear on the wire (start, preamble, SFD, payload, /T/ padded with
// idles, or /E/ for aborted frames) and chops it into 64-bit words. A compare
// process checks every non-idle output word, gap lengths and both counters on
// every cycle; literal expectations from hand calculation pin the model.
module tb_xgmii_frame_gen;

  localparam int MIN_IFG = 12;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [31:0] frame_count;
  logic [31:0] error_count;

  always #5 clk = ~clk;

  xgmii_frame_gen_if s_axis ();

  xgmii_frame_gen #(.MIN_IFG(MIN_IFG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axis      (s_axis),
    .xgmii_txd   (xgmii_txd),
    .xgmii_txc   (xgmii_txc),
    .frame_count (frame_count),
    .error_count (error_count)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    int          kind;      // 0 mid word, 1 last word of good frame, 2 error word
    int          idle_exp;  // exact idle words before this word, -1 = not checked
    bit          first;
    int          tail;      // bytes from /T/ inclusive in last word
  } exp_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    int          idles;
    int          cyc;
  } seen_t;

  exp_t  exp_q[$];
  seen_t seen_q[$];
  exp_t  cur_e;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    check_en = 1'b0;
  int    model_frames = 0;
  int    model_errors = 0;
  int    idle_run = 0;
  int    run_tail = -1;
  int    prev_tail_model = -1;

  function automatic logic [7:0] pat(input int id, input int j);
    return 8'((id * 37 + j * 5 + 1) & 255);
  endfunction

  // Expected wire words of one frame. cut >= 0: the beat with that index is
  // replaced by an /E/ word and nothing of the frame follows it.
  function automatic void push_frame(input int id, input int nbytes, input int cut, input bit exact);
    logic [7:0] b[$];
    bit         k[$];
    exp_t       e;
    int         iexp;
    int         nw;
    b.push_back(8'hFB); k.push_back(1'b1);
    for (int i = 0; i < 6; i++) begin b.push_back(8'h55); k.push_back(1'b0); end
    b.push_back(8'hD5); k.push_back(1'b0);
    if (cut < 0) begin
      for (int j = 0; j < nbytes; j++) begin b.push_back(pat(id, j)); k.push_back(1'b0); end
      b.push_back(8'hFD); k.push_back(1'b1);
      while (b.size() % 8 != 0) begin b.push_back(8'h07); k.push_back(1'b1); end
    end else begin
      for (int j = 0; j < cut * 8; j++) begin b.push_back(pat(id, j)); k.push_back(1'b0); end
      for (int j = 0; j < 8; j++) begin b.push_back(8'hFE); k.push_back(1'b1); end
    end
    iexp = -1;
    if (exact && prev_tail_model >= 0)
      iexp = (MIN_IFG > prev_tail_model) ? (MIN_IFG - prev_tail_model + 7) / 8 : 0;
    prev_tail_model = (cut < 0) ? (b.size() - (8 + nbytes)) : -1;
    nw = b.size() / 8;
    for (int w = 0; w < nw; w++) begin
      for (int i = 0; i < 8; i++) begin
        e.d[8*i +: 8] = b[w*8 + i];
        e.c[i]        = k[w*8 + i];
      end
      e.kind     = (w == nw - 1) ? ((cut < 0) ? 1 : 2) : 0;
      e.idle_exp = (w == 0) ? iexp : -1;
      e.first    = (w == 0);
      e.tail     = prev_tail_model;
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (check_en) begin
      if (xgmii_txd === IDLE_W && xgmii_txc === 8'hFF) begin
        idle_run++;
      end else begin
        seen_q.push_back('{d: xgmii_txd, c: xgmii_txc, idles: idle_run, cyc: cyc});
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h/%h, required idle", xgmii_txd, xgmii_txc);
        end else begin
          cur_e = exp_q.pop_front();
          if (xgmii_txd !== cur_e.d || xgmii_txc !== cur_e.c) begin
            errors++;
            $display("FAIL wire_word: got %h/%h, required %h/%h", xgmii_txd, xgmii_txc, cur_e.d, cur_e.c);
          end
          if (cur_e.idle_exp >= 0) begin
            checks++;
            if (idle_run != cur_e.idle_exp) begin
              errors++;
              $display("FAIL gap_idles: got %0d idle words, required %0d", idle_run, cur_e.idle_exp);
            end
          end
          if (cur_e.first && run_tail >= 0) begin
            checks++;
            if (run_tail + 8 * idle_run < MIN_IFG) begin
              errors++;
              $display("FAIL ifg_min: got %0d gap bytes, required >= %0d", run_tail + 8 * idle_run, MIN_IFG);
            end
          end
          if (cur_e.kind == 1) begin model_frames++; run_tail = cur_e.tail; end
          if (cur_e.kind == 2) begin model_errors++; run_tail = -1; end
        end
        idle_run = 0;
      end
      checks += 2;
      if (frame_count !== 32'(model_frames)) begin
        errors++;
        $display("FAIL frame_count: got %0d, required %0d", frame_count, model_frames);
      end
      if (error_count !== 32'(model_errors)) begin
        errors++;
        $display("FAIL error_count: got %0d, required %0d", error_count, model_errors);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int   waited;
    logic acc;
    s_axis.tdata  = d;
    s_axis.tkeep  = k;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    waited = 0;
    acc    = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = s_axis.tready;
      @(posedge clk);
      #1;
      waited++;
      if (!acc && waited > 200) begin
        checks++;
        errors++;
        $display("FAIL tready_timeout: got tready 0 for %0d cycles, required 1", waited);
        acc = 1'b1;
      end
    end
  endtask

  // mode 0 normal, 1 tvalid gap before beat cut, 2 bad tkeep on beat cut.
  task automatic send_frame(input int id, input int nbytes, input int cut, input int mode, input bit hold);
    int          nb;
    int          n;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    nb = (nbytes + 7) / 8;
    for (int bi = 0; bi < nb; bi++) begin
      if (mode == 1 && bi == cut) begin
        s_axis.tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      n = nbytes - 8 * bi;
      k = (n >= 8) ? 8'hFF : 8'((1 << n) - 1);
      l = (bi == nb - 1);
      for (int i = 0; i < 8; i++) d[8*i +: 8] = (8*bi + i < nbytes) ? pat(id, 8*bi + i) : 8'h00;
      if (mode == 2 && bi == cut) k = l ? 8'h0B : 8'h7F;
      drive_beat(d, k, l);
    end
    if (!hold) s_axis.tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d words still pending, required 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int mark;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tlast  = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("reset_txd", xgmii_txd, IDLE_W);
    chk("reset_txc", 64'(xgmii_txc), 64'hFF);
    chk("reset_tready", 64'(s_axis.tready), 64'h0);
    chk("reset_frame_count", 64'(frame_count), 64'h0);
    chk("reset_error_count", 64'(error_count), 64'h0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    check_en = 1'b1;

    // single 64-byte frame
    mark = seen_q.size();
    push_frame(1, 64, -1, 1'b0);
    send_frame(1, 64, -1, 0, 1'b0);
    wait_drain();
    chk("f64_preamble_d", seen_q[mark].d, 64'hD5555555555555FB);
    chk("f64_preamble_c", 64'(seen_q[mark].c), 64'h01);
    chk("f64_data_c", 64'(seen_q[mark+1].c), 64'h00);
    chk("f64_term_d", seen_q[mark+9].d, 64'h07070707070707FD);
    chk("f64_term_c", 64'(seen_q[mark+9].c), 64'hFF);
    chk("f64_frame_count", 64'(frame_count), 64'd1);

    // 61-byte frame followed back-to-back by a 64-byte frame
    mark = seen_q.size();
    push_frame(2, 61, -1, 1'b0);
    push_frame(3, 64, -1, 1'b1);
    send_frame(2, 61, -1, 0, 1'b1);
    send_frame(3, 64, -1, 0, 1'b0);
    wait_drain();
    chk("f61_last_c", 64'(seen_q[mark+8].c), 64'hE0);
    chk("f61_last_upper", 64'(seen_q[mark+8].d[63:40]), 64'h0707FD);
    chk("f61_gap_idles", 64'(seen_q[mark+9].idles), 64'd2);

    // three back-to-back 64-byte frames
    mark = seen_q.size();
    for (int i = 0; i < 3; i++) push_frame(4 + i, 64, -1, i != 0);
    for (int i = 0; i < 3; i++) send_frame(4 + i, 64, -1, 0, i < 2);
    wait_drain();
    chk("b2b_period_1", 64'(seen_q[mark+10].cyc - seen_q[mark].cyc), 64'd11);
    chk("b2b_period_2", 64'(seen_q[mark+20].cyc - seen_q[mark+10].cyc), 64'd11);
    chk("b2b_gap_idles", 64'(seen_q[mark+10].idles), 64'd1);
    chk("b2b_frame_count", 64'(frame_count), 64'd6);

    // underrun after three beats
    mark = seen_q.size();
    push_frame(7, 64, 3, 1'b0);
    send_frame(7, 64, 3, 1, 1'b0);
    wait_drain();
    chk("underrun_word_d", seen_q[mark+4].d, 64'hFEFEFEFEFEFEFEFE);
    chk("underrun_word_c", 64'(seen_q[mark+4].c), 64'hFF);
    chk("underrun_error_count", 64'(error_count), 64'd1);
    chk("underrun_frame_count", 64'(frame_count), 64'd6);

    // short frames: one byte and seven bytes in the last beat
    mark = seen_q.size();
    push_frame(8, 17, -1, 1'b0);
    send_frame(8, 17, -1, 0, 1'b0);
    wait_drain();
    chk("f17_last_c", 64'(seen_q[mark+3].c), 64'hFE);
    mark = seen_q.size();
    push_frame(9, 15, -1, 1'b0);
    send_frame(9, 15, -1, 0, 1'b0);
    wait_drain();
    chk("f15_last_c", 64'(seen_q[mark+2].c), 64'h80);

    // illegal tkeep on a last beat, then on a non-last beat
    push_frame(10, 24, 2, 1'b0);
    send_frame(10, 24, 2, 2, 1'b0);
    wait_drain();
    push_frame(11, 32, 1, 1'b0);
    send_frame(11, 32, 1, 2, 1'b0);
    wait_drain();
    chk("badkeep_error_count", 64'(error_count), 64'd3);
    push_frame(12, 40, -1, 1'b0);
    send_frame(12, 40, -1, 0, 1'b0);
    wait_drain();
    chk("recover_frame_count", 64'(frame_count), 64'd9);

    // reset in the middle of a frame
    check_en = 1'b0;
    for (int i = 0; i < 3; i++) drive_beat({8{8'(i + 8'h40)}}, 8'hFF, 1'b0);
    rst_n         = 1'b0;
    s_axis.tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_txd", xgmii_txd, IDLE_W);
    chk("midreset_txc", 64'(xgmii_txc), 64'hFF);
    chk("midreset_tready", 64'(s_axis.tready), 64'h0);
    chk("midreset_frame_count", 64'(frame_count), 64'h0);
    chk("midreset_error_count", 64'(error_count), 64'h0);
    exp_q.delete();
    model_frames    = 0;
    model_errors    = 0;
    run_tail        = -1;
    prev_tail_model = -1;
    idle_run        = 0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    check_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    push_frame(13, 64, -1, 1'b0);
    send_frame(13, 64, -1, 0, 1'b0);
    wait_drain();
    chk("post_reset_frame_count", 64'(frame_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
